// File: rtl/cache_pkg.sv
// Shared state encoding and default geometry for the cache refill controller.
// Address layout: tag | index | beat offset | 2'b00.
package cache_pkg;

  localparam int DEF_INDEX_W = 3;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_BEATS   = 4;
  localparam int DEF_DATA_W  = 32;

  localparam int OFF_LSB     = 2;
  localparam int DEF_OFF_W   = $clog2(DEF_BEATS);
  localparam int DEF_IDX_LSB = OFF_LSB + DEF_OFF_W;
  localparam int DEF_TAG_LSB = DEF_IDX_LSB + DEF_INDEX_W;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    MREQ,
    MDATA,
    FILL,
    RESP_HIT,
    RESP_MISS,
    FLUSH,
    FLUSH_DONE
  } state_e;

endpackage

// File: rtl/cache_refill_ctrl_beat_counter.sv
// Beat counter for line refills: wraps at BEATS, flags the last beat.
module refill_beat_counter
  import cache_pkg::*;
#(
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [OFF_W-1:0] cnt,
  output logic             last
);

  logic [OFF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = &cnt_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Lookup/refill/flush sequencer for a direct-mapped cache.
// Define REFILL_STATS_EN to add saturating hit/miss counters.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter  int INDEX_W = DEF_INDEX_W,
  parameter  int TAG_W   = DEF_TAG_W,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int BEATS   = DEF_BEATS,
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int OFF_W   = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               resp_valid,
  output logic               resp_hit,
  input  logic               flush_req,
  output logic               flush_done,
  output logic [INDEX_W-1:0] arr_index,
  input  logic               valid_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               valid_we,
  output logic               valid_clr,
  output logic               tag_we,
  output logic [TAG_W-1:0]   tag_wdata,
  output logic               data_we,
  output logic [OFF_W-1:0]   data_off,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
`ifdef REFILL_STATS_EN
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt,
`endif
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + INDEX_W;

  state_e             state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               beat_clr, beat_en, beat_last;
  logic [OFF_W-1:0]   beat;
  logic               hit;
  logic               unused_ok;

  // Data words go straight from memory to the array; only fields are used here.
  assign unused_ok = ^{mem_rdata, req_addr};

  assign hit = valid_in && (tag_in == tag_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    flush_pend_d = flush_pend_q | flush_req;
    beat_clr     = 1'b0;
    beat_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_pend_q || flush_req) begin
          state_d = FLUSH;
        end else if (req_valid) begin
          state_d = LOOKUP;
          idx_d   = req_addr[IDX_LSB +: INDEX_W];
          tag_d   = req_addr[TAG_LSB +: TAG_W];
        end
      end
      LOOKUP: state_d = hit ? RESP_HIT : MREQ;
      MREQ: begin
        if (mem_req_ready) begin
          state_d  = MDATA;
          beat_clr = 1'b1;
        end
      end
      MDATA: begin
        if (mem_rvalid) begin
          beat_en = 1'b1;
          if (beat_last) state_d = FILL;
        end
      end
      FILL:       state_d = RESP_MISS;
      RESP_HIT:   state_d = IDLE;
      RESP_MISS:  state_d = IDLE;
      FLUSH: begin
        state_d      = FLUSH_DONE;
        flush_pend_d = flush_req;
      end
      FLUSH_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      idx_q        <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
    end
  end

  refill_beat_counter #(
    .OFF_W (OFF_W)
  ) u_beat (
    .clk   (clk),
    .reset (reset),
    .clr   (beat_clr),
    .en    (beat_en),
    .cnt   (beat),
    .last  (beat_last)
  );

  // A same-cycle flush pulse beats a new lookup.
  assign req_ready = (state_q == IDLE) && !flush_pend_q && !flush_req;

  assign resp_valid    = (state_q == RESP_HIT) || (state_q == RESP_MISS);
  assign resp_hit      = (state_q == RESP_HIT);
  assign flush_done    = (state_q == FLUSH_DONE);
  assign valid_clr     = (state_q == FLUSH);
  assign tag_we        = (state_q == FILL);
  assign valid_we      = (state_q == FILL);
  assign mem_req_valid = (state_q == MREQ);
  assign data_we       = (state_q == MDATA) && mem_rvalid;
  assign data_off      = beat;
  assign arr_index     = idx_q;
  assign tag_wdata     = tag_q;

  always_comb begin
    mem_addr = '0;
    mem_addr[IDX_LSB +: INDEX_W] = idx_q;
    mem_addr[TAG_LSB +: TAG_W]   = tag_q;
  end

`ifdef REFILL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == FLUSH_DONE) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (state_q == RESP_HIT && hit_cnt_q != 16'hFFFF)
        hit_cnt_d = hit_cnt_q + 16'd1;
      if (state_q == RESP_MISS && miss_cnt_q != 16'hFFFF)
        miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed steps, then random lookups
// checked against a line-level scoreboard of valid bits and tags.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int IW = DEF_INDEX_W;
  localparam int TW = DEF_TAG_W;
  localparam int AW = DEF_ADDR_W;
  localparam int NB = DEF_BEATS;
  localparam int DW = DEF_DATA_W;
  localparam int OW = $clog2(NB);
  localparam int NL = 1 << IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic          resp_valid, resp_hit;
  logic [AW-1:0] req_addr, mem_addr;
  logic          flush_req, flush_done;
  logic [IW-1:0] arr_index;
  logic          valid_in, valid_we, valid_clr;
  logic          tag_we, data_we;
  logic [TW-1:0] tag_in, tag_wdata;
  logic [OW-1:0] data_off;
  logic          mem_req_valid, mem_req_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef REFILL_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .arr_index     (arr_index),
    .valid_in      (valid_in),
    .tag_in        (tag_in),
    .valid_we      (valid_we),
    .valid_clr     (valid_clr),
    .tag_we        (tag_we),
    .tag_wdata     (tag_wdata),
    .data_we       (data_we),
    .data_off      (data_off),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
`ifdef REFILL_STATS_EN
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
`endif
    .mem_rdata     (mem_rdata)
  );

  // Cache arrays around the controller, written by its strobes.
  logic          vmod [NL];
  logic [TW-1:0] tmod [NL];
  logic [DW-1:0] dmod [NL][NB];
  logic          poke_en;
  logic [IW-1:0] poke_idx;
  logic [TW-1:0] poke_tag;

  always @(posedge clk) begin
    if (valid_clr)
      for (int i = 0; i < NL; i++) vmod[i] <= 1'b0;
    if (valid_we) vmod[arr_index] <= 1'b1;
    if (tag_we) tmod[arr_index] <= tag_wdata;
    if (data_we) dmod[arr_index][data_off] <= mem_rdata;
    if (poke_en) begin
      vmod[poke_idx] <= 1'b1;
      tmod[poke_idx] <= poke_tag;
    end
  end

  assign valid_in = vmod[arr_index];
  assign tag_in   = tmod[arr_index];

  // Scoreboard: which lines are valid and with what tag.
  logic          ev [NL];
  logic [TW-1:0] et [NL];
  int ncmp = 0;
  int nerr = 0;
  int mh = 0;
  int mm = 0;

  task automatic chk(input string tg, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] vbits();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = vmod[i];
    return v;
  endfunction

  task automatic chk_rst_outs();
    chk("rst_ready", req_ready, 1);
    chk("rst_ctl", {resp_valid, resp_hit, flush_done, valid_we,
                    valid_clr, tag_we, data_we, mem_req_valid}, 0);
    chk("rst_index", arr_index, 0);
    chk("rst_tagw", tag_wdata, 0);
    chk("rst_off", data_off, 0);
    chk("rst_maddr", mem_addr, 0);
  endtask

  task automatic chk_stats();
`ifdef REFILL_STATS_EN
    chk("hit_cnt", hit_cnt, mh);
    chk("miss_cnt", miss_cnt, mm);
`endif
  endtask

  task automatic flush_tail();
    int k = 0;
    while (!valid_clr && k < 4) begin
      chk("ready_pend", req_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("flush_clr", valid_clr, 1);
    chk("ready_clr", req_ready, 0);
    @(negedge clk);
    chk("flush_done", flush_done, 1);
    chk("clr_once", valid_clr, 0);
    chk("ready_done", req_ready, 0);
    @(negedge clk);
    chk("done_pulse", flush_done, 0);
    chk("ready_idle", req_ready, 1);
    for (int i = 0; i < NL; i++) ev[i] = 1'b0;
    chk("arr_cleared", vbits(), 0);
    mh = 0;
    mm = 0;
    chk_stats();
  endtask

  task automatic do_flush_idle();
    @(negedge clk);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_addr  = AW'($urandom);
    #1 chk("flush_wins", req_ready, 0);
    @(negedge clk);
    flush_req = 1'b0;
    req_valid = 1'b0;
    flush_tail();
  endtask

  task automatic poke(input logic [IW-1:0] i, input logic [TW-1:0] t);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = i;
    poke_tag = t;
    @(negedge clk);
    poke_en = 1'b0;
    ev[i] = 1'b1;
    et[i] = t;
  endtask

  task automatic do_req(input logic [AW-1:0] addr, input int wait_n,
                        input int gmode, input int fl_beat,
                        input int rs_beat);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    logic [AW-1:0] maddr;
    logic [DW-1:0] line [NB];
    logic exp_hit, macc, fl_sent, alt, done, beat_now;
    int beats, w, g, cyc;
    idx   = addr[DEF_IDX_LSB +: IW];
    tg    = addr[DEF_TAG_LSB +: TW];
    maddr = '0;
    maddr[DEF_IDX_LSB +: IW] = idx;
    maddr[DEF_TAG_LSB +: TW] = tg;
    exp_hit = ev[idx] && (et[idx] == tg);
    macc = 0; fl_sent = 0; alt = 1; done = 0;
    beats = 0; w = 0; g = 0; cyc = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1 chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    chk("arr_index", arr_index, idx);
    while (!done && cyc < 300) begin
      chk("ready_busy", req_ready, 0);
      chk("clr_busy", valid_clr, 0);
      if (exp_hit) chk("no_mreq", mem_req_valid, 0);
      if (mem_req_valid) chk("mem_addr", mem_addr, maddr);
      if (tag_we || valid_we) begin
        chk("fill_pair", {tag_we, valid_we}, 2'b11);
        chk("fill_beats", beats, NB);
        chk("tag_wdata", tag_wdata, tg);
        chk("fill_index", arr_index, idx);
      end
      if (resp_valid) begin
        chk("resp_hit", resp_hit, exp_hit);
        chk("latency", cyc, exp_hit ? 1 : 7 + w + g);
        done = 1'b1;
      end
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      flush_req     = 1'b0;
      mem_rdata     = DW'($urandom);
      beat_now      = 1'b0;
      if (!macc) begin
        if (mem_req_valid) begin
          if (w < wait_n) w++;
          else mem_req_ready = 1'b1;
        end
        mem_rvalid = ($urandom_range(3) == 0);
      end else if (beats < NB) begin
        if ((gmode == 1 && alt) ||
            (gmode == 2 && $urandom_range(2) == 0)) begin
          g++;
        end else begin
          mem_rvalid = 1'b1;
          beat_now   = 1'b1;
        end
        alt = !alt;
      end else begin
        mem_rvalid = ($urandom_range(1) == 1);
      end
      if (macc && !fl_sent && fl_beat >= 0 && beats == fl_beat) begin
        flush_req = 1'b1;
        fl_sent   = 1'b1;
      end
      if (macc && rs_beat >= 0 && beats == rs_beat) begin
        reset      = 1'b0;
        mem_rvalid = 1'b0;
        #1 chk_rst_outs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_line", vmod[idx], ev[idx]);
        chk("rst_ready_rel", req_ready, 1);
        mh = 0;
        mm = 0;
        chk_stats();
        return;
      end
      #1;
      if (beat_now) begin
        chk("data_we", data_we, 1);
        chk("data_off", data_off, beats);
        line[beats] = mem_rdata;
        beats++;
      end else begin
        chk("data_we_off", data_we, 0);
      end
      if (mem_req_ready) macc = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("resp_timeout", 0, 1);
    mem_rvalid = 1'b0;
    flush_req  = 1'b0;
    chk("resp_pulse", resp_valid, 0);
    if (exp_hit) begin
      mh++;
    end else begin
      mm++;
      ev[idx] = 1'b1;
      et[idx] = tg;
    end
    chk("arr_valid", vmod[idx], ev[idx]);
    chk("arr_tag", tmod[idx], et[idx]);
    if (!exp_hit)
      for (int b = 0; b < NB; b++) chk("arr_data", dmod[idx][b], line[b]);
    chk_stats();
    if (fl_sent) flush_tail();
    else chk("ready_after", req_ready, 1);
  endtask

  initial begin
    logic [AW-1:0] a;
    int fb;
    reset = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    flush_req = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    poke_en = 1'b0;
    poke_idx = '0;
    poke_tag = '0;
    for (int i = 0; i < NL; i++) begin
      ev[i] = 1'b0;
      et[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_rst_outs();
    reset = 1'b1;
    @(negedge clk);
    chk("ready_out_of_rst", req_ready, 1);

    do_flush_idle();
    do_req(16'h0124, 0, 0, -1, -1);
    do_req(16'h0124, 0, 0, -1, -1);
    poke(3'd2, 8'h05);
    do_req(16'h0124, 0, 0, -1, -1);
    do_req(16'h0124, 0, 0, -1, -1);
    do_req(16'h0A38, 6, 1, -1, -1);
    do_req(16'h1150, 2, 2, 1, -1);
    do_req(16'h0240, 1, 0, -1, 2);
    do_req(16'h0240, 0, 1, -1, -1);
    do_req(16'h0244, 0, 0, -1, -1);

    repeat (40) begin
      a = '0;
      a[DEF_TAG_LSB +: TW] = TW'($urandom_range(2));
      a[DEF_IDX_LSB +: IW] = IW'($urandom_range(NL - 1));
      a[OFF_LSB +: OW]     = OW'($urandom_range(NB - 1));
      a[AW-1]              = 1'($urandom_range(1));
      fb = ($urandom_range(7) == 0) ? int'($urandom_range(NB - 1)) : -1;
      do_req(a, int'($urandom_range(3)), int'($urandom_range(2)), fb, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
